cozy_regfile_debug: RTL

Debug access controller for the cozy core's 16×16 register file (R0 hardwired to zero, one write port, two combinational read ports). It sits between the core and the register file. Through a valid/ready request/response channel it halts the core, then reads, writes or dumps registers. It resumes the core on command. While the core runs, the core's register-file signals pass through untouched.

---
 rtl/cozy_regfile_debug.sv | 150 +++++++++++++++
 1 files changed

// File: rtl/cozy_regfile_debug.sv
// rtl/cozy_regfile_debug.sv - debug access controller between the cozy core and its 16x16 register file
// Halts the core on request, then serves READ/WRITE/DUMP over a valid/ready channel until RESUME.

module cozy_regfile_debug #(
  parameter int unsigned DUMP_FIRST = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [3:0]  core_rD_sel,
  input  logic        core_rD_we,
  input  logic [15:0] core_rD_in,
  input  logic [3:0]  core_rS_sel,
  input  logic        core_halted,
  output logic        core_halt_req,
  output logic [3:0]  rf_rD_sel,
  output logic        rf_rD_we,
  output logic [15:0] rf_rD_in,
  output logic [3:0]  rf_rS_sel,
  input  logic [15:0] rf_rS_out,
  input  logic        dbg_req_valid,
  output logic        dbg_req_ready,
  input  logic [1:0]  dbg_req_op,
  input  logic [3:0]  dbg_req_reg,
  input  logic [15:0] dbg_req_data,
  output logic        dbg_rsp_valid,
  input  logic        dbg_rsp_ready,
  output logic [3:0]  dbg_rsp_reg,
  output logic [15:0] dbg_rsp_data,
  output logic        dbg_rsp_last
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_HALT   = 2'd1,
    S_ACCESS = 2'd2,
    S_RESP   = 2'd3
  } state_t;

  localparam logic [1:0] OP_READ   = 2'd0;
  localparam logic [1:0] OP_WRITE  = 2'd1;
  localparam logic [1:0] OP_DUMP   = 2'd2;
  localparam logic [1:0] OP_RESUME = 2'd3;
  localparam logic [3:0] DUMP_FIRST_REG = 4'(DUMP_FIRST);

  state_t      state_q, state_d;
  logic [1:0]  op_q;
  logic [3:0]  cur_reg_q;
  logic [15:0] data_q;
  logic        halt_req_q;
  logic [3:0]  rsp_reg_q;
  logic [15:0] rsp_data_q;
  logic        rsp_last_q;

  logic accept;
  logic dump_more;
  logic owned;

  assign accept    = dbg_req_valid && (state_q == S_IDLE);
  assign dump_more = (op_q == OP_DUMP) && (cur_reg_q != 4'hF);
  assign owned     = halt_req_q && core_halted;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          if (dbg_req_op == OP_RESUME) begin
            state_d = S_RESP;
          end else if (core_halted) begin
            state_d = S_ACCESS;
          end else begin
            state_d = S_HALT;
          end
        end
      end
      S_HALT: begin
        if (core_halted) begin
          state_d = S_ACCESS;
        end
      end
      S_ACCESS: state_d = S_RESP;
      S_RESP: begin
        if (dbg_rsp_ready) begin
          state_d = dump_more ? S_ACCESS : S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Request fields are latched once so later changes on the request bus are ignored.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_q       <= OP_READ;
      cur_reg_q  <= 4'd0;
      data_q     <= 16'd0;
      halt_req_q <= 1'b0;
      rsp_reg_q  <= 4'd0;
      rsp_data_q <= 16'd0;
      rsp_last_q <= 1'b0;
    end else if (accept) begin
      op_q      <= dbg_req_op;
      data_q    <= dbg_req_data;
      cur_reg_q <= (dbg_req_op == OP_DUMP) ? DUMP_FIRST_REG : dbg_req_reg;
      if (dbg_req_op == OP_RESUME) begin
        halt_req_q <= 1'b0;
        rsp_reg_q  <= 4'd0;
        rsp_data_q <= 16'd0;
        rsp_last_q <= 1'b1;
      end else begin
        halt_req_q <= 1'b1;
      end
    end else if (state_q == S_ACCESS) begin
      rsp_reg_q  <= cur_reg_q;
      rsp_data_q <= (op_q == OP_WRITE) ? data_q : rf_rS_out;
      rsp_last_q <= !dump_more;
    end else if ((state_q == S_RESP) && dbg_rsp_ready && dump_more) begin
      cur_reg_q <= cur_reg_q + 4'd1;
    end
  end

  always_comb begin
    dbg_req_ready = (state_q == S_IDLE);
    dbg_rsp_valid = (state_q == S_RESP);
    dbg_rsp_reg   = rsp_reg_q;
    dbg_rsp_data  = rsp_data_q;
    dbg_rsp_last  = rsp_last_q;
    core_halt_req = halt_req_q;
    rf_rD_sel     = core_rD_sel;
    rf_rD_we      = core_rD_we;
    rf_rD_in      = core_rD_in;
    rf_rS_sel     = core_rS_sel;
    // Debug owns the file only while the core has actually acknowledged the halt.
    if (owned) begin
      rf_rD_sel = cur_reg_q;
      rf_rS_sel = cur_reg_q;
      rf_rD_in  = data_q;
      rf_rD_we  = (state_q == S_ACCESS) && (op_q == OP_WRITE);
    end
  end

endmodule
